// File: rtl/hwag_pkg.sv
// Shared definitions for the coil scheduler: angle width, last valid angle
// count before the generator wraps, and the per-channel coil state type.
package hwag_pkg;

  localparam int ANG_WIDTH = 24;
  localparam int HWAMAXACR = 3839;

  typedef enum logic [1:0] {
    CH_OFF     = 2'd0,
    CH_DWELL   = 2'd1,
    CH_LOCKOUT = 2'd2
  } ch_state_t;

endpackage

// File: rtl/hwag_coil_channel.sv
// One ignition coil channel: active set/reset angles, dwell FSM with a
// saturating dwell-time counter, and a sticky timeout flag.
module hwag_coil_channel #(
  parameter int ANG_WIDTH   = hwag_pkg::ANG_WIDTH,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANG_WIDTH-1:0]   acnt,
  input  logic                   load,
  input  logic [ANG_WIDTH-1:0]   load_set,
  input  logic [ANG_WIDTH-1:0]   load_reset,
  input  logic [DWELL_WIDTH-1:0] max_dwell,
  output logic                   coil,
  output logic                   fault
);
  import hwag_pkg::*;

  ch_state_t              state;
  ch_state_t              state_next;
  logic [ANG_WIDTH-1:0]   act_set;
  logic [ANG_WIDTH-1:0]   act_reset;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [DWELL_WIDTH-1:0] dwell_inc;
  logic                   in_range;
  logic                   hit_set;
  logic                   hit_reset;
  logic                   timeout;

  // Angle matches (angles past the wrap point never match) and the timeout test on the next counter value
  always_comb begin
    in_range  = (acnt <= ANG_WIDTH'(HWAMAXACR));
    hit_set   = in_range && (acnt == act_set);
    hit_reset = in_range && (acnt == act_reset);
    dwell_inc = (&dwell_cnt) ? dwell_cnt : dwell_cnt + DWELL_WIDTH'(1);
    timeout   = (max_dwell != '0) && (dwell_inc >= max_dwell);
  end

  // Next-state logic: losing sync forces OFF, reset angle beats set angle and timeout
  always_comb begin
    state_next = state;
    if (!hwag_start) begin
      state_next = CH_OFF;
    end else begin
      case (state)
        CH_OFF:     if (hit_set && !hit_reset) state_next = CH_DWELL;
        CH_DWELL: begin
          if (hit_reset)    state_next = CH_OFF;
          else if (timeout) state_next = CH_LOCKOUT;
        end
        CH_LOCKOUT: if (hit_reset) state_next = CH_OFF;
        default:    state_next = CH_OFF;
      endcase
    end
  end

  // State, registered coil drive, sticky fault and dwell counter (cleared on entry, counting while dwelling)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CH_OFF;
      coil      <= 1'b0;
      fault     <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state <= state_next;
      coil  <= (state_next == CH_DWELL);
      if (state == CH_DWELL && state_next == CH_LOCKOUT) fault <= 1'b1;
      if (state != CH_DWELL && state_next == CH_DWELL) dwell_cnt <= '0;
      else if (state == CH_DWELL)                      dwell_cnt <= dwell_inc;
    end
  end

  // Active angles change only when the top level applies a commit on a wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      act_set   <= '0;
      act_reset <= '0;
    end else if (load) begin
      act_set   <= load_set;
      act_reset <= load_reset;
    end
  end

endmodule

// File: rtl/hwag_coil_sched.sv
// Angle-based coil scheduler: per-channel shadow angle registers written by
// software, copied to all channels at once on the first wrap after a commit.
module hwag_coil_sched #(
  parameter int CH_NUM      = 4,
  parameter int ANG_WIDTH   = hwag_pkg::ANG_WIDTH,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hwag_start,
  input  logic [ANG_WIDTH-1:0]      acnt,
  input  logic                      acnt_wrap,
  input  logic                      cfg_we,
  input  logic [$clog2(CH_NUM)-1:0] cfg_ch,
  input  logic                      cfg_sel,
  input  logic [ANG_WIDTH-1:0]      cfg_data,
  input  logic                      cfg_commit,
  input  logic [DWELL_WIDTH-1:0]    max_dwell,
  output logic                      cfg_pending,
  output logic [CH_NUM-1:0]         coil_out,
  output logic [CH_NUM-1:0]         dwell_fault
);
  import hwag_pkg::*;

  logic [ANG_WIDTH-1:0] shadow_set       [CH_NUM];
  logic [ANG_WIDTH-1:0] shadow_reset     [CH_NUM];
  logic [ANG_WIDTH-1:0] shadow_set_next  [CH_NUM];
  logic [ANG_WIDTH-1:0] shadow_reset_next[CH_NUM];
  logic                 apply;

  // Shadow contents after this clock's write, so a write landing on the applying wrap is copied too
  always_comb begin
    shadow_set_next   = shadow_set;
    shadow_reset_next = shadow_reset;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        if (cfg_sel) shadow_reset_next[i] = cfg_data;
        else         shadow_set_next[i]   = cfg_data;
      end
    end
    apply = acnt_wrap && (cfg_pending || cfg_commit);
  end

  // Shadow registers and the pending-commit flag; a commit on the wrap itself applies without pending
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        shadow_set[i]   <= '0;
        shadow_reset[i] <= '0;
      end
      cfg_pending <= 1'b0;
    end else begin
      shadow_set   <= shadow_set_next;
      shadow_reset <= shadow_reset_next;
      if (apply)           cfg_pending <= 1'b0;
      else if (cfg_commit) cfg_pending <= 1'b1;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    hwag_coil_channel #(
      .ANG_WIDTH  (ANG_WIDTH),
      .DWELL_WIDTH(DWELL_WIDTH)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .hwag_start(hwag_start),
      .acnt      (acnt),
      .load      (apply),
      .load_set  (shadow_set_next[g]),
      .load_reset(shadow_reset_next[g]),
      .max_dwell (max_dwell),
      .coil      (coil_out[g]),
      .fault     (dwell_fault[g])
    );
  end

endmodule
